// File: rtl/ternary_match_decoder_if.sv
// ---------------------------------------------------------------------------
// ternary_match_decoder_if
// Bundles the table-configuration port, the lookup request and the resolved
// result of ternary_match_decoder.
//   master : drives cfg_* and in_*, observes out_*, err_* and viol_count
//   slave  : the decoder side
// Parameters must agree with the decoder instance (IDX_W = $clog2(ENTRIES)).
// ---------------------------------------------------------------------------
interface ternary_match_decoder_if #(
  parameter int KEY_W  = 3,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
);
  // Table write port
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_valid;
  logic [KEY_W-1:0]  cfg_value;
  logic [KEY_W-1:0]  cfg_mask;
  logic [DATA_W-1:0] cfg_data;
  // Lookup request
  logic              in_valid;
  logic [KEY_W-1:0]  in_key;
  // Resolved result
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_hit;
  logic [IDX_W-1:0]  out_idx;
  logic              out_multi;
  logic              err_viol;
  logic              err_x;
  logic [15:0]       viol_count;

  modport master (
    output cfg_we, cfg_idx, cfg_valid, cfg_value, cfg_mask, cfg_data,
    output in_valid, in_key,
    input  out_valid, out_data, out_hit, out_idx, out_multi,
    input  err_viol, err_x, viol_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_valid, cfg_value, cfg_mask, cfg_data,
    input  in_valid, in_key,
    output out_valid, out_data, out_hit, out_idx, out_multi,
    output err_viol, err_x, viol_count
  );
endinterface

// File: rtl/ternary_match_decoder.sv
// ---------------------------------------------------------------------------
// ternary_match_decoder
// Runtime-programmable wildcard decode table with a two-stage pipeline.
// Each entry holds {valid, value, care-mask, data}; a key matches an entry
// when every cared bit equals the stored value. The lowest-index match
// supplies out_data; MODE selects which match counts are flagged:
//   0 = priority (never flagged), 1 = unique (count != 1), 2 = unique0 (count > 1)
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (clears table, pipeline, counter)
//   bus  : ternary_match_decoder_if.slave (cfg_*, in_*, out_*, err_*, viol_count)
// Optional feature: define TERNARY_MATCH_XCHECK_EN to flag X/Z lookup keys
// on err_x (simulation guard; the $isunknown test is constant 0 in synthesis).
// ---------------------------------------------------------------------------
module ternary_match_decoder #(
  parameter int                KEY_W        = 3,
  parameter int                DATA_W       = 8,
  parameter int                ENTRIES      = 4,
  parameter int                MODE         = 0,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 8'hFF
) (
  input logic                    clk,
  input logic                    rst,
  ternary_match_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  // Match table
  logic [ENTRIES-1:0] tbl_valid_q, tbl_valid_d;
  logic [KEY_W-1:0]   tbl_value_q [ENTRIES];
  logic [KEY_W-1:0]   tbl_value_d [ENTRIES];
  logic [KEY_W-1:0]   tbl_mask_q  [ENTRIES];
  logic [KEY_W-1:0]   tbl_mask_d  [ENTRIES];
  logic [DATA_W-1:0]  tbl_data_q  [ENTRIES];
  logic [DATA_W-1:0]  tbl_data_d  [ENTRIES];

  // Stage 1 combinational compare
  logic [ENTRIES-1:0] match_vec;
  logic [DATA_W-1:0]  first_data;
  logic               x_key;

  // Stage 1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [ENTRIES-1:0] s1_match_q, s1_match_d;
  logic [DATA_W-1:0]  s1_data_q,  s1_data_d;
  logic               s1_x_q,     s1_x_d;

  // Stage 2 resolution
  logic [CNT_W-1:0]   match_cnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_hit;
  logic               many_hit;
  logic               viol;

  // Stage 2 registers (module outputs)
  logic               out_valid_q,  out_valid_d;
  logic [DATA_W-1:0]  out_data_q,   out_data_d;
  logic               out_hit_q,    out_hit_d;
  logic [IDX_W-1:0]   out_idx_q,    out_idx_d;
  logic               out_multi_q,  out_multi_d;
  logic               err_viol_q,   err_viol_d;
  logic               err_x_q,      err_x_d;
  logic [15:0]        viol_count_q, viol_count_d;

  // Table write: the addressed entry takes the cfg fields, all others hold.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
        tbl_valid_d[i] = bus.cfg_valid;
        tbl_value_d[i] = bus.cfg_value;
        tbl_mask_d[i]  = bus.cfg_mask;
        tbl_data_d[i]  = bus.cfg_data;
      end else begin
        tbl_valid_d[i] = tbl_valid_q[i];
        tbl_value_d[i] = tbl_value_q[i];
        tbl_mask_d[i]  = tbl_mask_q[i];
        tbl_data_d[i]  = tbl_data_q[i];
      end
    end
  end

  // Table storage; reset invalidates every entry and clears its fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_valid_q <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_value_q[i] <= {KEY_W{1'b0}};
        tbl_mask_q[i]  <= {KEY_W{1'b0}};
        tbl_data_q[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      tbl_valid_q <= tbl_valid_d;
      tbl_value_q <= tbl_value_d;
      tbl_mask_q  <= tbl_mask_d;
      tbl_data_q  <= tbl_data_d;
    end
  end

  // Parallel compare against the current (pre-write) table.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      match_vec[i] = tbl_valid_q[i] & ~(|((bus.in_key ^ tbl_value_q[i]) & tbl_mask_q[i]));
    end
    x_key = 1'b0;
`ifdef TERNARY_MATCH_XCHECK_EN
    if (bus.in_valid && $isunknown(bus.in_key)) begin
      x_key     = 1'b1;
      match_vec = {ENTRIES{1'b0}};
    end else begin
      x_key     = 1'b0;
    end
`endif
    // Result data is latched with the match vector so a write landing while
    // the lookup is in stage 2 cannot change an already-compared result.
    first_data = DEFAULT_DATA;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      first_data = match_vec[i] ? tbl_data_q[i] : first_data;
    end
    s1_valid_d = bus.in_valid;
    s1_match_d = match_vec;
    s1_data_d  = first_data;
    s1_x_d     = x_key;
  end

  // Stage 1 pipeline register; reset drops any lookup in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= {ENTRIES{1'b0}};
      s1_data_q  <= DEFAULT_DATA;
      s1_x_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_match_q <= s1_match_d;
      s1_data_q  <= s1_data_d;
      s1_x_q     <= s1_x_d;
    end
  end

  // Resolve the match vector: count, lowest index, mode rule, idle values.
  always_comb begin
    match_cnt = {CNT_W{1'b0}};
    sel_idx   = {IDX_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      match_cnt = match_cnt + CNT_W'(s1_match_q[i]);
      sel_idx   = s1_match_q[i] ? IDX_W'(i) : sel_idx;
    end
    any_hit  = |s1_match_q;
    many_hit = (match_cnt > CNT_W'(1));
    case (MODE)
      32'sd0:  viol = 1'b0;
      32'sd1:  viol = (match_cnt != CNT_W'(1));
      32'sd2:  viol = many_hit;
      default: viol = 1'b0;
    endcase

    out_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      out_data_d  = s1_data_q;
      out_hit_d   = any_hit;
      out_idx_d   = sel_idx;
      out_multi_d = many_hit;
      err_viol_d  = viol;
      err_x_d     = s1_x_q;
    end else begin
      out_data_d  = DEFAULT_DATA;
      out_hit_d   = 1'b0;
      out_idx_d   = {IDX_W{1'b0}};
      out_multi_d = 1'b0;
      err_viol_d  = 1'b0;
      err_x_d     = 1'b0;
    end

    // Counter moves together with the flagged result it counts.
    if (out_valid_d && err_viol_d && (viol_count_q != 16'hFFFF)) begin
      viol_count_d = viol_count_q + 16'd1;
    end else begin
      viol_count_d = viol_count_q;
    end
  end

  // Stage 2 / output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= DEFAULT_DATA;
      out_hit_q    <= 1'b0;
      out_idx_q    <= {IDX_W{1'b0}};
      out_multi_q  <= 1'b0;
      err_viol_q   <= 1'b0;
      err_x_q      <= 1'b0;
      viol_count_q <= 16'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_hit_q    <= out_hit_d;
      out_idx_q    <= out_idx_d;
      out_multi_q  <= out_multi_d;
      err_viol_q   <= err_viol_d;
      err_x_q      <= err_x_d;
      viol_count_q <= viol_count_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_hit    = out_hit_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_multi  = out_multi_q;
  assign bus.err_viol   = err_viol_q;
  assign bus.err_x      = err_x_q;
  assign bus.viol_count = viol_count_q;
endmodule

// File: tb/tb_ternary_match_decoder.sv
// Bench for ternary_match_decoder: three instances (priority, unique, unique0)
// share one stimulus stream; expectations come from a table model in the bench.
module tb_ternary_match_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ternary_match_decoder_if #(.KEY_W(3), .DATA_W(8), .IDX_W(2)) bus0 ();
  ternary_match_decoder_if #(.KEY_W(3), .DATA_W(8), .IDX_W(2)) bus1 ();
  ternary_match_decoder_if #(.KEY_W(3), .DATA_W(8), .IDX_W(2)) bus2 ();

  assign bus1.cfg_we    = bus0.cfg_we;
  assign bus1.cfg_idx   = bus0.cfg_idx;
  assign bus1.cfg_valid = bus0.cfg_valid;
  assign bus1.cfg_value = bus0.cfg_value;
  assign bus1.cfg_mask  = bus0.cfg_mask;
  assign bus1.cfg_data  = bus0.cfg_data;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_key    = bus0.in_key;
  assign bus2.cfg_we    = bus0.cfg_we;
  assign bus2.cfg_idx   = bus0.cfg_idx;
  assign bus2.cfg_valid = bus0.cfg_valid;
  assign bus2.cfg_value = bus0.cfg_value;
  assign bus2.cfg_mask  = bus0.cfg_mask;
  assign bus2.cfg_data  = bus0.cfg_data;
  assign bus2.in_valid  = bus0.in_valid;
  assign bus2.in_key    = bus0.in_key;

  ternary_match_decoder #(.MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ternary_match_decoder #(.MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ternary_match_decoder #(.MODE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Observed outputs per mode: {valid, data, hit, idx, multi, viol, x, count}
  logic [30:0] o_vec [3];
  assign o_vec[0] = {bus0.out_valid, bus0.out_data, bus0.out_hit, bus0.out_idx,
                     bus0.out_multi, bus0.err_viol, bus0.err_x, bus0.viol_count};
  assign o_vec[1] = {bus1.out_valid, bus1.out_data, bus1.out_hit, bus1.out_idx,
                     bus1.out_multi, bus1.err_viol, bus1.err_x, bus1.viol_count};
  assign o_vec[2] = {bus2.out_valid, bus2.out_data, bus2.out_hit, bus2.out_idx,
                     bus2.out_multi, bus2.err_viol, bus2.err_x, bus2.viol_count};

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       hit;
    logic [1:0] idx;
    logic       multi;
    logic [2:0] viol;   // viol[m] = flag expected from the MODE m instance
    logic       x;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference table and per-mode violation counters
  logic       m_valid [4];
  logic [2:0] m_value [4];
  logic [2:0] m_mask  [4];
  logic [7:0] m_data  [4];
  logic [15:0] m_vc   [3];

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.data = 8'hFF;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic h, input logic [1:0] ix,
                              input logic mu, input logic v0, input logic v1,
                              input logic v2, input logic xx);
    exp_t e;
    e.valid = 1'b1; e.data = d; e.hit = h; e.idx = ix; e.multi = mu;
    e.viol = {v2, v1, v0}; e.x = xx;
    return e;
  endfunction

  // Lookup from the table model: masked key equals masked value.
  function automatic exp_t model_lookup(input logic [2:0] key);
    exp_t e;
    int n = 0;
    int first = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && ((key & m_mask[i]) == (m_value[i] & m_mask[i]))) begin
        n++;
        if (first < 0) first = i;
      end
    end
    e.valid = 1'b1;
    e.hit   = (n > 0);
    e.data  = (n > 0) ? m_data[first] : 8'hFF;
    e.idx   = (n > 0) ? 2'(first) : 2'd0;
    e.multi = (n > 1);
    e.viol  = {(n > 1), (n != 1), 1'b0};
    e.x     = 1'b0;
    return e;
  endfunction

  // Expected vector for mode m; advances that mode's counter when the result flags.
  function automatic logic [30:0] exp_vec(input exp_t e, input int m);
    if (e.valid && e.viol[m] && m_vc[m] != 16'hFFFF) m_vc[m] = m_vc[m] + 16'd1;
    return {e.valid, e.data, e.hit, e.idx, e.multi, e.viol[m], e.x, m_vc[m]};
  endfunction

  task automatic set_wr(input logic [1:0] idx, input logic v, input logic [2:0] val,
                        input logic [2:0] msk, input logic [7:0] dat);
    bus0.cfg_we = 1'b1; bus0.cfg_idx = idx; bus0.cfg_valid = v;
    bus0.cfg_value = val; bus0.cfg_mask = msk; bus0.cfg_data = dat;
  endtask

  task automatic set_lk(input logic [2:0] key);
    bus0.in_valid = 1'b1; bus0.in_key = key;
  endtask

  // One clock: model follows writes/reset, strobes drop at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      for (int m = 0; m < 3; m++) m_vc[m] = 16'd0;
    end else if (bus0.cfg_we) begin
      m_valid[bus0.cfg_idx] = bus0.cfg_valid;
      m_value[bus0.cfg_idx] = bus0.cfg_value;
      m_mask[bus0.cfg_idx]  = bus0.cfg_mask;
      m_data[bus0.cfg_idx]  = bus0.cfg_data;
    end
    @(negedge clk);
    bus0.cfg_we   = 1'b0;
    bus0.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] ev;
    rst = 1'b1;
    tick();
    tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(idle_exp(), m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL reset mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
    rst = 1'b0;
  endtask

  // Plan table, keys 000/010/111 back to back, checked in all three modes.
  task automatic test_back_to_back();
    logic [2:0]  keys [3];
    exp_t        exps [4];
    logic [30:0] ev;
    keys[0] = 3'b000; keys[1] = 3'b010; keys[2] = 3'b111;
    exps[0] = mk(8'hA0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    exps[1] = mk(8'hB0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exps[2] = mk(8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exps[3] = idle_exp();
    set_wr(2'd0, 1'b1, 3'b000, 3'b111, 8'hA0); tick();
    set_wr(2'd1, 1'b1, 3'b000, 3'b101, 8'hB0); tick();
    for (int t = 0; t < 5; t++) begin
      if (t < 3) set_lk(keys[t]);
      tick();
      if (t >= 1) begin
        for (int m = 0; m < 3; m++) begin
          ev = exp_vec(exps[t-1], m);
          checks++;
          if (o_vec[m] !== ev) begin
            errors++;
            $display("FAIL b2b step%0d mode%0d got %h exp %h", t - 1, m, o_vec[m], ev);
          end
        end
      end
    end
  endtask

  // Write and lookup of the same entry in one cycle, then repeated writes.
  task automatic test_collision();
    exp_t        exps [4];
    logic [30:0] ev;
    exps[0] = mk(8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exps[1] = mk(8'hC3, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exps[2] = mk(8'hD2, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exps[3] = idle_exp();
    set_wr(2'd2, 1'b1, 3'b011, 3'b111, 8'hC3); set_lk(3'b011); tick();
    set_wr(2'd3, 1'b1, 3'b110, 3'b111, 8'hD1); set_lk(3'b011); tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(exps[0], m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL collision_old mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
    set_wr(2'd3, 1'b1, 3'b110, 3'b111, 8'hD2); tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(exps[1], m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL collision_new mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
    set_lk(3'b110); tick(); tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(exps[2], m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL last_write_wins mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
  endtask

  // Reset while a lookup is in flight, with a write attempted during reset.
  task automatic test_reset_mid();
    exp_t        e;
    logic [30:0] ev;
    e = model_lookup(3'b000);
    set_lk(3'b000); tick();
    set_lk(3'b010); tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(e, m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL pre_reset mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
    rst = 1'b1;
    set_wr(2'd3, 1'b1, 3'b000, 3'b000, 8'hEE);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int m = 0; m < 3; m++) begin
        ev = exp_vec(idle_exp(), m);
        checks++;
        if (o_vec[m] !== ev) begin
          errors++;
          $display("FAIL flush t%0d mode%0d got %h exp %h", t, m, o_vec[m], ev);
        end
      end
      tick();
    end
    e = mk(8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_lk(3'b000); tick(); tick();
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(e, m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL table_cleared mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
  endtask

  // Random writes and lookups against the table model.
  task automatic test_random();
    exp_t        prev;
    exp_t        cur;
    logic [30:0] ev;
    logic [2:0]  key;
    prev = idle_exp();
    for (int n = 0; n < 301; n++) begin
      cur = idle_exp();
      if (n < 300) begin
        if ($urandom_range(3) == 0)
          set_wr(2'($urandom_range(3)), ($urandom_range(3) != 0), 3'($urandom),
                 3'($urandom) & 3'($urandom), 8'($urandom));
        if ($urandom_range(3) != 0) begin
          key = 3'($urandom);
          cur = model_lookup(key);
          set_lk(key);
        end
      end
      tick();
      for (int m = 0; m < 3; m++) begin
        ev = exp_vec(prev, m);
        checks++;
        if (o_vec[m] !== ev) begin
          errors++;
          $display("FAIL random n%0d mode%0d got %h exp %h", n, m, o_vec[m], ev);
        end
      end
      prev = cur;
    end
  endtask

  // Unknown key with every entry matching everything.
  task automatic test_xcheck();
    logic [2:0]  xk;
    logic        kx;
    exp_t        e;
    logic [30:0] ev;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(2'(i), 1'b1, 3'b000, 3'b000, 8'h10 + 8'(i));
      tick();
    end
    xk = 3'b0x1;
    kx = $isunknown(xk);
    set_lk(xk); tick(); tick();
`ifdef TERNARY_MATCH_XCHECK_EN
    e = kx ? mk(8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)
           : mk(8'h10, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(e, m);
      checks++;
      if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL xcheck mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
`else
    e = mk(8'h10, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 3; m++) begin
      ev = exp_vec(e, m);
      checks++;
      if (kx) begin
        if ({o_vec[m][30], o_vec[m][16]} !== 2'b10) begin
          errors++;
          $display("FAIL xcheck_off mode%0d got valid/err_x %b%b exp 10",
                   m, o_vec[m][30], o_vec[m][16]);
        end
      end else if (o_vec[m] !== ev) begin
        errors++;
        $display("FAIL xcheck_off mode%0d got %h exp %h", m, o_vec[m], ev);
      end
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus0.cfg_we = 1'b0; bus0.cfg_idx = 2'd0; bus0.cfg_valid = 1'b0;
    bus0.cfg_value = 3'd0; bus0.cfg_mask = 3'd0; bus0.cfg_data = 8'd0;
    bus0.in_valid = 1'b0; bus0.in_key = 3'd0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_value[i] = 3'd0; m_mask[i] = 3'd0; m_data[i] = 8'd0;
    end
    for (int m = 0; m < 3; m++) m_vc[m] = 16'd0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    test_random();
    test_xcheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
